bus_arb2: RTL

- Two-master to one-slave arbiter for the core valid/ready cmd/rsp memory bus.
- Master 0 is the core bus controller; master 1 is a secondary requester (debug/DMA).
- Grants one command at a time and tracks an outstanding read so its response returns only to the issuing master.
- Optional response watchdog converts a hung read into an error response.

---
 rtl/bus_arb2_pkg.sv | 14 +
 rtl/bus_arb2_pick2.sv | 22 ++
 rtl/bus_arb2.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/bus_arb2_pkg.sv
// Shared types and bus-width defaults for the two-master memory bus arbiter.
// Width defaults track the core memory bus so instances stay drop-in compatible.
package bus_arb2_pkg;

    localparam int MEM_BUS      = 32;
    localparam int MEM_ADDR_BUS = 32;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_HOLD = 2'd1,
        ARB_RSP  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/bus_arb2_pick2.sv
// Combinational two-way request picker used by bus_arb2 in its IDLE state.
// PRIO_MODE = 0 alternates on contention against last_gnt; 1 always favours req[0].
module arb_pick2 #(
    parameter int PRIO_MODE = 0
) (
    input  logic [1:0] req,
    input  logic       last_gnt,
    output logic       gnt,
    output logic       any
);

    always_comb begin
        any = |req;
        gnt = 1'b0;
        if (&req) begin
            gnt = (PRIO_MODE != 0) ? 1'b0 : ~last_gnt;
        end else if (req[1]) begin
            gnt = 1'b1;
        end
    end

endmodule

// File: rtl/bus_arb2.sv
// Two-master to one-slave valid/ready arbiter with single outstanding read
// tracking and an optional response watchdog that turns a hung read into an error.
module bus_arb2
    import bus_arb2_pkg::*;
#(
    parameter int DW        = MEM_BUS,
    parameter int AW        = MEM_ADDR_BUS,
    parameter int PRIO_MODE = 0,
    parameter int TIMEOUT   = 0,
    parameter int TW        = 16
) (
    input  logic          clk,
    input  logic          rst,

    input  logic [DW-1:0] m0_cmd_wdata,
    input  logic [AW-1:0] m0_cmd_addr,
    input  logic          m0_cmd_we,
    input  logic [3:0]    m0_cmd_wem,
    input  logic          m0_cmd_valid,
    output logic          m0_cmd_ready,
    output logic [DW-1:0] m0_rsp_rdata,
    output logic          m0_rsp_valid,
    input  logic          m0_rsp_ready,
    output logic          m0_rsp_error,

    input  logic [DW-1:0] m1_cmd_wdata,
    input  logic [AW-1:0] m1_cmd_addr,
    input  logic          m1_cmd_we,
    input  logic [3:0]    m1_cmd_wem,
    input  logic          m1_cmd_valid,
    output logic          m1_cmd_ready,
    output logic [DW-1:0] m1_rsp_rdata,
    output logic          m1_rsp_valid,
    input  logic          m1_rsp_ready,
    output logic          m1_rsp_error,

    output logic [DW-1:0] s_cmd_wdata,
    output logic [AW-1:0] s_cmd_addr,
    output logic          s_cmd_we,
    output logic [3:0]    s_cmd_wem,
    output logic          s_cmd_valid,
    input  logic          s_cmd_ready,
    input  logic [DW-1:0] s_rsp_rdata,
    input  logic          s_rsp_valid,
    output logic          s_rsp_ready,
    input  logic          s_rsp_error
);

    localparam logic [TW-1:0] TLIM  = TW'(TIMEOUT);
    localparam bit            WD_EN = (TIMEOUT > 0);

    arb_state_t    st, st_nxt;
    logic          owner, owner_nxt;
    logic          last_gnt, last_gnt_nxt;
    logic [TW-1:0] tcnt, tcnt_nxt;

    logic [1:0]    req;
    logic          pick_gnt, pick_any;
    logic          sel, fwd, wd_fire;
    logic          own_rsp_ready;
    logic          rsp_v, rsp_e;
    logic [DW-1:0] rsp_d;

    assign req           = {m1_cmd_valid, m0_cmd_valid};
    assign own_rsp_ready = owner ? m1_rsp_ready : m0_rsp_ready;
    assign wd_fire       = WD_EN && (tcnt == TLIM);

    arb_pick2 #(
        .PRIO_MODE (PRIO_MODE)
    ) u_pick (
        .req      (req),
        .last_gnt (last_gnt),
        .gnt      (pick_gnt),
        .any      (pick_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            st       <= ARB_IDLE;
            owner    <= 1'b0;
            last_gnt <= 1'b1;
            tcnt     <= '0;
        end else begin
            st       <= st_nxt;
            owner    <= owner_nxt;
            last_gnt <= last_gnt_nxt;
            tcnt     <= tcnt_nxt;
        end
    end

    always_comb begin
        st_nxt       = st;
        owner_nxt    = owner;
        last_gnt_nxt = last_gnt;
        tcnt_nxt     = tcnt;

        sel   = owner;
        fwd   = 1'b0;
        rsp_v = 1'b0;
        rsp_e = 1'b0;
        rsp_d = '0;

        s_cmd_wdata  = '0;
        s_cmd_addr   = '0;
        s_cmd_we     = 1'b0;
        s_cmd_wem    = '0;
        s_cmd_valid  = 1'b0;
        s_rsp_ready  = 1'b0;
        m0_cmd_ready = 1'b0;
        m1_cmd_ready = 1'b0;
        m0_rsp_valid = 1'b0;
        m0_rsp_error = 1'b0;
        m0_rsp_rdata = '0;
        m1_rsp_valid = 1'b0;
        m1_rsp_error = 1'b0;
        m1_rsp_rdata = '0;

        case (st)
            ARB_IDLE: begin
                sel = pick_gnt;
                fwd = pick_any;
            end
            ARB_HOLD: begin
                // Locked to the owner; a dropped valid abandons the command.
                sel = owner;
                fwd = owner ? m1_cmd_valid : m0_cmd_valid;
                if (!fwd) begin
                    st_nxt = ARB_IDLE;
                end
            end
            ARB_RSP: begin
                rsp_v       = s_rsp_valid;
                rsp_e       = s_rsp_error;
                rsp_d       = s_rsp_rdata;
                s_rsp_ready = own_rsp_ready;
                // A real slave response wins over a watchdog expiry in the same cycle.
                if (!s_rsp_valid && wd_fire) begin
                    rsp_v       = 1'b1;
                    rsp_e       = 1'b1;
                    rsp_d       = '0;
                    s_rsp_ready = 1'b0;
                end
                if (!s_rsp_valid && WD_EN && (tcnt != TLIM)) begin
                    tcnt_nxt = tcnt + TW'(1);
                end
                if (rsp_v && own_rsp_ready) begin
                    st_nxt = ARB_IDLE;
                end
            end
            default: begin
                st_nxt = ARB_IDLE;
            end
        endcase

        if (fwd) begin
            s_cmd_valid  = 1'b1;
            s_cmd_wdata  = sel ? m1_cmd_wdata : m0_cmd_wdata;
            s_cmd_addr   = sel ? m1_cmd_addr  : m0_cmd_addr;
            s_cmd_we     = sel ? m1_cmd_we    : m0_cmd_we;
            s_cmd_wem    = sel ? m1_cmd_wem   : m0_cmd_wem;
            m0_cmd_ready = !sel && s_cmd_ready;
            m1_cmd_ready =  sel && s_cmd_ready;
            owner_nxt    = sel;
            if (s_cmd_ready) begin
                last_gnt_nxt = sel;
                if (s_cmd_we) begin
                    st_nxt = ARB_IDLE;
                end else begin
                    tcnt_nxt = '0;
                    st_nxt   = ARB_RSP;
                end
            end else begin
                st_nxt = ARB_HOLD;
            end
        end

        if (owner) begin
            m1_rsp_valid = rsp_v;
            m1_rsp_error = rsp_e;
            m1_rsp_rdata = rsp_d;
        end else begin
            m0_rsp_valid = rsp_v;
            m0_rsp_error = rsp_e;
            m0_rsp_rdata = rsp_d;
        end

        if (rst) begin
            s_cmd_wdata  = '0;
            s_cmd_addr   = '0;
            s_cmd_we     = 1'b0;
            s_cmd_wem    = '0;
            s_cmd_valid  = 1'b0;
            s_rsp_ready  = 1'b0;
            m0_cmd_ready = 1'b0;
            m1_cmd_ready = 1'b0;
            m0_rsp_valid = 1'b0;
            m0_rsp_error = 1'b0;
            m0_rsp_rdata = '0;
            m1_rsp_valid = 1'b0;
            m1_rsp_error = 1'b0;
            m1_rsp_rdata = '0;
        end
    end

endmodule
